// File: rtl/slt_compare_arbiter.sv
// slt_compare_arbiter
//   Lets N_REQ requesters share one compare datapath (SLT, SLTU, signed MIN, signed MAX).
//   Requests are granted round-robin. The result goes into a single registered response
//   stage, so a result appears one cycle after its request is accepted.
//
// Ports
//   clk_i         clock; all state changes on the rising edge
//   rst_n_i       asynchronous active-low reset
//   req_valid_i   [N_REQ]        request i valid
//   req_ready_o   [N_REQ]        request i accepted this cycle (one-hot or zero)
//   req_x_i       [N_REQ*WIDTH]  operand X of requester i at [i*WIDTH +: WIDTH]
//   req_y_i       [N_REQ*WIDTH]  operand Y of requester i, packed the same way
//   req_op_i      [N_REQ*2]      op of requester i: 00 SLT, 01 SLTU, 10 MIN, 11 MAX
//   rsp_valid_o                  response register holds a result
//   rsp_ready_i                  consumer takes the response this cycle
//   rsp_id_o      [3]            requester that produced rsp_data_o
//   rsp_data_o    [WIDTH]        result
module slt_compare_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [N_REQ-1:0]       req_valid_i,
  output logic [N_REQ-1:0]       req_ready_o,
  input  logic [N_REQ*WIDTH-1:0] req_x_i,
  input  logic [N_REQ*WIDTH-1:0] req_y_i,
  input  logic [N_REQ*2-1:0]     req_op_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [2:0]             rsp_id_o,
  output logic [WIDTH-1:0]       rsp_data_o
);

  localparam logic [1:0] OP_SLT  = 2'b00;
  localparam logic [1:0] OP_SLTU = 2'b01;
  localparam logic [1:0] OP_MIN  = 2'b10;

  logic [2:0]       ptr_q, ptr_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [2:0]       rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic             gnt_found;
  logic [2:0]       gnt_idx;
  logic             can_accept;
  logic             xfer;
  logic [WIDTH-1:0] x_sel, y_sel;
  logic [1:0]       op_sel;
  logic [WIDTH:0]   diff;
  logic             lt_s, lt_u, lt;
  logic [WIDTH-1:0] result;

  // Round-robin search done as two passes: first from ptr up to N_REQ-1, then
  // the wrap-around part 0..ptr-1. Constant indices keep the selects static.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!gnt_found && req_valid_i[i] && (3'(i) >= ptr_q)) begin
        gnt_found = 1'b1;
        gnt_idx   = 3'(i);
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!gnt_found && req_valid_i[i] && (3'(i) < ptr_q)) begin
        gnt_found = 1'b1;
        gnt_idx   = 3'(i);
      end
    end
  end

  // Nothing is accepted while reset is held, even though the empty response
  // register would otherwise allow it.
  assign can_accept = rst_n_i && (!rsp_valid_q || rsp_ready_i);
  assign xfer       = can_accept && gnt_found;

  always_comb begin
    req_ready_o = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (xfer && (3'(i) == gnt_idx)) req_ready_o[i] = 1'b1;
    end
  end

  always_comb begin
    x_sel  = '0;
    y_sel  = '0;
    op_sel = OP_SLT;
    for (int i = 0; i < N_REQ; i++) begin
      if (3'(i) == gnt_idx) begin
        x_sel  = req_x_i[i*WIDTH +: WIDTH];
        y_sel  = req_y_i[i*WIDTH +: WIDTH];
        op_sel = req_op_i[i*2 +: 2];
      end
    end
  end

  // One subtractor serves both compares: the extra top bit is the unsigned
  // borrow, and with equal signs the difference sign is the signed result.
  assign diff = {1'b0, x_sel} - {1'b0, y_sel};
  assign lt_u = diff[WIDTH];
  assign lt_s = (x_sel[WIDTH-1] ^ y_sel[WIDTH-1]) ? x_sel[WIDTH-1] : diff[WIDTH-1];
  assign lt   = (op_sel == OP_SLTU) ? lt_u : lt_s;

  always_comb begin
    result = '0;
    case (op_sel)
      OP_SLT, OP_SLTU: result = {{(WIDTH-1){1'b0}}, lt};
      OP_MIN:          result = lt ? x_sel : y_sel;
      default:         result = lt ? y_sel : x_sel;
    endcase
  end

  always_comb begin
    ptr_d       = ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    if (xfer) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = gnt_idx;
      rsp_data_d  = result;
      ptr_d       = (gnt_idx == 3'(N_REQ-1)) ? 3'd0 : gnt_idx + 3'd1;
    end else if (rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_data_o  = rsp_data_q;

endmodule

// File: tb/tb_slt_compare_arbiter.sv
module tb_slt_compare_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_x;
  logic [N*W-1:0] req_y;
  logic [N*2-1:0] req_op;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [2:0]     rsp_id;
  logic [W-1:0]   rsp_data;

  int checks   = 0;
  int failures = 0;
  logic [34:0] exp_q[$];

  slt_compare_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_x_i     (req_x),
    .req_y_i     (req_y),
    .req_op_i    (req_op),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_id_o    (rsp_id),
    .rsp_data_o  (rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
    req_valid[i]      = 1'b1;
    req_op[i*2 +: 2]  = op;
    req_x[i*W +: W]   = x;
    req_y[i*W +: W]   = y;
  endtask

  // Single request from requester i; expected response queued for the monitor.
  task automatic issue(input int i, input logic [1:0] op, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] exp_data);
    set_req(i, op, x, y);
    exp_q.push_back({3'(i), exp_data});
    @(negedge clk);
    chk("issue_ready", 64'(req_ready), 64'(4'b0001 << i));
    step();
    req_valid = '0;
  endtask

  // Monitor: every response handshake is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL rsp_unexpected got id=%0d data=%h want none", rsp_id, rsp_data);
      end else begin
        logic [34:0] e;
        e = exp_q.pop_front();
        if ({rsp_id, rsp_data} !== e) begin
          failures++;
          $display("FAIL rsp got id=%0d data=%h want id=%0d data=%h",
                   rsp_id, rsp_data, e[34:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [3:0] rr_ready [5];
    logic [3:0] sk_ready [4];
    rst_n = 1'b0;
    req_valid = '0; req_x = '0; req_y = '0; req_op = '0;
    rsp_ready = 1'b1;
    repeat (2) step();
    chk("rst_valid", 64'(rsp_valid), 64'd0);
    chk("rst_data",  64'(rsp_data),  64'd0);
    chk("rst_id",    64'(rsp_id),    64'd0);
    set_req(0, 2'b00, 32'd1, 32'd2);
    #1;
    chk("rst_ready", 64'(req_ready), 64'd0);
    req_valid = '0;
    rst_n = 1'b1;
    step();

    // signed SLT
    issue(0, 2'b00, 32'hFFFF_FFFF, 32'd1, 32'd1);
    issue(0, 2'b00, 32'h7FFF_FFFF, 32'h8000_0000, 32'd0);
    // SLTU / MIN / MAX, ptr walks 1 -> 2 -> 3 -> 0
    issue(1, 2'b01, 32'd1, 32'hFFFF_FFFF, 32'd1);
    issue(2, 2'b10, 32'hFFFF_FFFB, 32'd3, 32'hFFFF_FFFB);
    issue(3, 2'b11, 32'd7, 32'd7, 32'd7);
    @(negedge clk);
    step();

    // reset mid-operation with a pending, unconsumed response
    rsp_ready = 1'b0;
    set_req(0, 2'b00, 32'hFFFF_FFFF, 32'd1);
    @(negedge clk);
    chk("mid_ready", 64'(req_ready), 64'b0001);
    step();
    chk("mid_pend_valid", 64'(rsp_valid), 64'd1);
    chk("mid_pend_data",  64'(rsp_data),  64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(rsp_valid), 64'd0);
    chk("mid_rst_data",  64'(rsp_data),  64'd0);
    chk("mid_rst_ready", 64'(req_ready), 64'd0);
    step();
    chk("mid_rst_ready2", 64'(req_ready), 64'd0);
    chk("mid_rst_valid2", 64'(rsp_valid), 64'd0);
    req_valid = '0;
    rsp_ready = 1'b1;
    rst_n = 1'b1;
    step();

    // round-robin with all requesters valid, ptr=0 after reset
    set_req(0, 2'b00, 32'hFFFF_FFFD, 32'd2);
    set_req(1, 2'b01, 32'hFFFF_FFFD, 32'd2);
    set_req(2, 2'b10, 32'd10, 32'hFFFF_FFEC);
    set_req(3, 2'b11, 32'd10, 32'hFFFF_FFEC);
    exp_q.push_back({3'd0, 32'd1});
    exp_q.push_back({3'd1, 32'd0});
    exp_q.push_back({3'd2, 32'hFFFF_FFEC});
    exp_q.push_back({3'd3, 32'd10});
    exp_q.push_back({3'd0, 32'd1});
    rr_ready = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("rr_ready%0d", k), 64'(req_ready), 64'(rr_ready[k]));
      step();
    end
    req_valid = '0;

    // backpressure: last rr response (id 0, data 1) held while req2 waits
    rsp_ready = 1'b0;
    set_req(2, 2'b11, 32'd5, 32'd9);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("bp_ready%0d", k), 64'(req_ready), 64'd0);
      chk($sformatf("bp_valid%0d", k), 64'(rsp_valid), 64'd1);
      chk($sformatf("bp_id%0d", k),    64'(rsp_id),    64'd0);
      chk($sformatf("bp_data%0d", k),  64'(rsp_data),  64'd1);
      step();
    end
    rsp_ready = 1'b1;
    exp_q.push_back({3'd2, 32'd9});
    @(negedge clk);
    chk("bp_release_ready", 64'(req_ready), 64'b0100);
    step();
    req_valid = '0;

    // move ptr to 2, then only req1 and req3 valid
    issue(1, 2'b00, 32'd0, 32'd0, 32'd0);
    set_req(1, 2'b00, 32'hFFFF_FFFF, 32'd0);
    set_req(3, 2'b10, 32'd4, 32'hFFFF_FFFF);
    exp_q.push_back({3'd3, 32'hFFFF_FFFF});
    exp_q.push_back({3'd1, 32'd1});
    exp_q.push_back({3'd3, 32'hFFFF_FFFF});
    exp_q.push_back({3'd1, 32'd1});
    sk_ready = '{4'b1000, 4'b0010, 4'b1000, 4'b0010};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("skip_ready%0d", k), 64'(req_ready), 64'(sk_ready[k]));
      step();
    end
    req_valid = '0;

    repeat (3) step();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
